// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encodings, widths and screen constants for the game sequencer
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_LOST  = 3'd4,
        S_OVER  = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    localparam int LIVES_W = 2;
    localparam int BLK_W   = 6;

    // Screen centre where the ball is parked while ball_start is low.
    localparam int X0 = 320;
    localparam int Y0 = 240;

    // Output pattern owned by each state: {ball_start, game_over, win}.
    function automatic logic [2:0] state_outputs(input state_t s);
        logic [2:0] o;
        o = 3'b000;
        case (s)
            S_PLAY:  o = 3'b100;
            S_PAUSE: o = 3'b110;
            S_OVER:  o = 3'b010;
            S_WIN:   o = 3'b011;
            default: o = 3'b000;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - rising-edge detector: one history flop and an AND gate
// Ports: clock, reset (async, active-high), d (level in), rise (high for the cycle d first reads high).
module edge_det (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - Breakout round sequencer: lives, score, blocks, serve delay, pause, win/over
// Ports: clock, reset (async, active-high); btn_start, btn_pause, frame_tick, endgame_ball, hit_block in;
//        ball_start, game_over, win, lives, score, blocks_left, state out (all registered).
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES       = 3,
    parameter int N_BLOCKS    = 40,
    parameter int SERVE_DELAY = 60,
    parameter int BLOCK_PTS   = 1,
    parameter int SCORE_W     = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               frame_tick,
    input  logic               endgame_ball,
    input  logic               hit_block,
    output logic               ball_start,
    output logic               game_over,
    output logic               win,
    output logic [LIVES_W-1:0] lives,
    output logic [SCORE_W-1:0] score,
    output logic [BLK_W-1:0]   blocks_left,
    output logic [2:0]         state
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
    localparam logic [BLK_W-1:0]   BLK_INIT   = BLK_W'(N_BLOCKS);
    localparam logic [BLK_W-1:0]   BLK_ONE    = BLK_W'(1);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_DELAY - 1);
    localparam logic [SCORE_W:0]   PTS        = (SCORE_W + 1)'(BLOCK_PTS);

    state_t               state_q;
    logic [7:0]           serve_cnt;
    logic                 start_rise, pause_rise, hit_rise, end_rise;
    logic [SCORE_W:0]     score_sum;
    logic [SCORE_W-1:0]   score_sat;

    edge_det u_start (.clock(clock), .reset(reset), .d(btn_start),    .rise(start_rise));
    edge_det u_pause (.clock(clock), .reset(reset), .d(btn_pause),    .rise(pause_rise));
    edge_det u_hit   (.clock(clock), .reset(reset), .d(hit_block),    .rise(hit_rise));
    edge_det u_end   (.clock(clock), .reset(reset), .d(endgame_ball), .rise(end_rise));

    // One extra bit catches the carry so the score pins at all-ones instead of wrapping.
    always_comb begin
        score_sum = {1'b0, score} + PTS;
        score_sat = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    assign state = state_q;

    // Outputs are loaded with the pattern of the state being entered, so they
    // change on the same edge as state_q.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q                  <= S_IDLE;
            lives                    <= LIVES_INIT;
            score                    <= '0;
            blocks_left              <= BLK_INIT;
            serve_cnt                <= '0;
            {ball_start, game_over, win} <= 3'b000;
        end else begin
            case (state_q)
                S_IDLE, S_OVER, S_WIN: begin
                    if (start_rise) begin
                        state_q                      <= S_SERVE;
                        {ball_start, game_over, win} <= state_outputs(S_SERVE);
                        lives                        <= LIVES_INIT;
                        score                        <= '0;
                        blocks_left                  <= BLK_INIT;
                        serve_cnt                    <= '0;
                    end
                end
                S_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            state_q                      <= S_PLAY;
                            {ball_start, game_over, win} <= state_outputs(S_PLAY);
                            serve_cnt                    <= '0;
                        end else begin
                            serve_cnt <= serve_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // The block is always credited, even when the ball is lost on the same cycle.
                    if (hit_rise) begin
                        score <= score_sat;
                        if (blocks_left != '0) begin
                            blocks_left <= blocks_left - BLK_ONE;
                        end
                    end
                    if (hit_rise && blocks_left == BLK_ONE) begin
                        state_q                      <= S_WIN;
                        {ball_start, game_over, win} <= state_outputs(S_WIN);
                    end else if (end_rise) begin
                        state_q                      <= S_LOST;
                        {ball_start, game_over, win} <= state_outputs(S_LOST);
                    end else if (pause_rise) begin
                        state_q                      <= S_PAUSE;
                        {ball_start, game_over, win} <= state_outputs(S_PAUSE);
                    end
                end
                S_PAUSE: begin
                    if (pause_rise) begin
                        state_q                      <= S_PLAY;
                        {ball_start, game_over, win} <= state_outputs(S_PLAY);
                    end
                end
                S_LOST: begin
                    if (lives <= LIVES_ONE) begin
                        lives                        <= '0;
                        state_q                      <= S_OVER;
                        {ball_start, game_over, win} <= state_outputs(S_OVER);
                    end else begin
                        lives                        <= lives - LIVES_ONE;
                        serve_cnt                    <= '0;
                        state_q                      <= S_SERVE;
                        {ball_start, game_over, win} <= state_outputs(S_SERVE);
                    end
                end
                default: begin
                    state_q                      <= S_IDLE;
                    {ball_start, game_over, win} <= state_outputs(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - self-checking bench for game_ctrl against a rule-level game model
module tb_game_ctrl;

    localparam int P_LIVES = 3;
    localparam int P_NB    = 2;
    localparam int P_SD    = 3;
    localparam int P_PTS   = 600;
    localparam int P_SW    = 10;
    localparam int SMAX    = (1 << P_SW) - 1;

    localparam int ST_IDLE = 0, ST_SERVE = 1, ST_PLAY = 2, ST_PAUSE = 3;
    localparam int ST_LOST = 4, ST_OVER = 5, ST_WIN = 6;

    logic clock, reset;
    logic btn_start, btn_pause, frame_tick, endgame_ball, hit_block;
    logic ball_start, game_over, win;
    logic [1:0] lives;
    logic [P_SW-1:0] score;
    logic [5:0] blocks_left;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    // Reference model of the game rules.
    int m_state, m_lives, m_score, m_blocks, m_serve;
    bit p_start, p_pause, p_hit, p_end;

    game_ctrl #(
        .LIVES(P_LIVES), .N_BLOCKS(P_NB), .SERVE_DELAY(P_SD),
        .BLOCK_PTS(P_PTS), .SCORE_W(P_SW)
    ) dut (
        .clock(clock), .reset(reset),
        .btn_start(btn_start), .btn_pause(btn_pause), .frame_tick(frame_tick),
        .endgame_ball(endgame_ball), .hit_block(hit_block),
        .ball_start(ball_start), .game_over(game_over), .win(win),
        .lives(lives), .score(score), .blocks_left(blocks_left), .state(state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_lives = P_LIVES; m_score = 0; m_blocks = P_NB; m_serve = 0;
        p_start = 0; p_pause = 0; p_hit = 0; p_end = 0;
    endtask

    task automatic new_game();
        m_state = ST_SERVE; m_lives = P_LIVES; m_score = 0; m_blocks = P_NB; m_serve = 0;
    endtask

    // Apply one clock edge worth of game rules to the model, using the inputs present at that edge.
    task automatic model_edge();
        bit se, pe, he, ee;
        int was_blocks;
        if (reset) begin
            model_reset();
            return;
        end
        se = btn_start && !p_start;
        pe = btn_pause && !p_pause;
        he = hit_block && !p_hit;
        ee = endgame_ball && !p_end;
        p_start = btn_start; p_pause = btn_pause; p_hit = hit_block; p_end = endgame_ball;
        case (m_state)
            ST_IDLE, ST_OVER, ST_WIN: if (se) new_game();
            ST_SERVE: if (frame_tick) begin
                m_serve++;
                if (m_serve == P_SD) begin
                    m_serve = 0;
                    m_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                was_blocks = m_blocks;
                if (he) begin
                    m_score = (m_score + P_PTS > SMAX) ? SMAX : m_score + P_PTS;
                    if (m_blocks > 0) m_blocks--;
                end
                if (he && was_blocks == 1) m_state = ST_WIN;
                else if (ee)               m_state = ST_LOST;
                else if (pe)               m_state = ST_PAUSE;
            end
            ST_PAUSE: if (pe) m_state = ST_PLAY;
            ST_LOST: begin
                m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                m_state = (m_lives == 0) ? ST_OVER : ST_SERVE;
                m_serve = 0;
            end
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(state), m_state);
        chk({tag, ".lives"}, 32'(lives), m_lives);
        chk({tag, ".score"}, 32'(score), m_score);
        chk({tag, ".blocks_left"}, 32'(blocks_left), m_blocks);
        chk({tag, ".ball_start"}, 32'(ball_start), (m_state == ST_PLAY || m_state == ST_PAUSE) ? 1 : 0);
        chk({tag, ".win"}, 32'(win), (m_state == ST_WIN) ? 1 : 0);
        if (m_state != ST_SERVE && m_state != ST_LOST)
            chk({tag, ".game_over"}, 32'(game_over),
                (m_state == ST_PAUSE || m_state == ST_OVER || m_state == ST_WIN) ? 1 : 0);
    endtask

    task automatic cyc(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    task automatic serve_ticks(input string tag);
        for (int t = 0; t < P_SD; t++) begin
            cyc(9, tag);
            chk({tag, ".held"}, 32'(ball_start), 0);
            frame_tick = 1'b1;
            cyc(1, tag);
            frame_tick = 1'b0;
        end
    endtask

    task automatic press_start(input string tag);
        btn_start = 1'b1;
        cyc(1, tag);
        btn_start = 1'b0;
        cyc(1, tag);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        btn_start = 0; btn_pause = 0; frame_tick = 0; endgame_ball = 0; hit_block = 0;
        model_reset();
        cyc(2, "reset");
        chk("reset_state", 32'(state), ST_IDLE);
        chk("reset_lives", 32'(lives), P_LIVES);
        reset = 1'b0;
        cyc(2, "idle");

        // Serve timing
        press_start("start1");
        chk("serve_state", 32'(state), ST_SERVE);
        serve_ticks("serve1");
        chk("play_after_serve", 32'(state), ST_PLAY);
        chk("launch", 32'(ball_start), 1);

        // Held hit counts once, then a hit coinciding with a loss clears the level
        hit_block = 1'b1;
        cyc(5, "hold_hit");
        hit_block = 1'b0;
        cyc(1, "hit_release");
        chk("score_single", 32'(score), P_PTS);
        chk("blocks_one", 32'(blocks_left), 1);
        hit_block = 1'b1; endgame_ball = 1'b1;
        cyc(1, "last_and_loss");
        chk("win_state", 32'(state), ST_WIN);
        chk("win_flag", 32'(win), 1);
        chk("win_lives", 32'(lives), P_LIVES);
        chk("score_sat", 32'(score), SMAX);
        chk("blocks_zero", 32'(blocks_left), 0);
        hit_block = 1'b0; endgame_ball = 1'b0;
        cyc(2, "win_hold");

        // Pause ignores hits and losses
        press_start("start2");
        serve_ticks("serve2");
        btn_pause = 1'b1; cyc(1, "pause_on"); btn_pause = 1'b0; cyc(1, "pause_on");
        chk("pause_state", 32'(state), ST_PAUSE);
        chk("pause_freeze", 32'(game_over), 1);
        hit_block = 1'b1; endgame_ball = 1'b1; cyc(2, "pause_evt");
        hit_block = 1'b0; endgame_ball = 1'b0; cyc(1, "pause_evt");
        btn_pause = 1'b1; cyc(1, "pause_off"); btn_pause = 1'b0; cyc(1, "pause_off");
        chk("resume_state", 32'(state), ST_PLAY);
        chk("resume_blocks", 32'(blocks_left), P_NB);

        // Lose every ball
        for (int k = 1; k <= P_LIVES; k++) begin
            endgame_ball = 1'b1;
            cyc(1, "lose");
            n = 0;
            while (ball_start && n < 5) begin
                cyc(1, "lose_wait");
                n++;
            end
            chk("lose_bound", 32'(n < 5), 1);
            endgame_ball = 1'b0;
            cyc(1, "lost");
            chk("lives_left", 32'(lives), P_LIVES - k);
            if (k < P_LIVES) serve_ticks("reserve");
        end
        chk("over_state", 32'(state), ST_OVER);
        chk("over_go", 32'(game_over), 1);
        endgame_ball = 1'b1; cyc(2, "over_raise");
        endgame_ball = 1'b0; cyc(1, "over_raise");
        chk("over_lives", 32'(lives), 0);

        // Asynchronous reset between edges in SERVE
        press_start("start3");
        frame_tick = 1'b1; cyc(1, "pre_rst"); frame_tick = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_state", 32'(state), ST_IDLE);
        cyc(2, "in_rst");
        reset = 1'b0;
        cyc(1, "post_rst");
        chk("post_rst_lives", 32'(lives), P_LIVES);

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 499) == 0);
            btn_start    = ($urandom_range(0, 7) == 0);
            btn_pause    = ($urandom_range(0, 11) == 0);
            frame_tick   = ($urandom_range(0, 1) == 0);
            hit_block    = ($urandom_range(0, 5) == 0);
            endgame_ball = ($urandom_range(0, 15) == 0);
            cyc(1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level round sequencer for the Breakout game. Drives the ball's `start` and `endgame` inputs and consumes its `endgame_ball` and `hit_block` outputs.
- Owns the lives, score and remaining-block bookkeeping, the serve delay after each lost ball, pause, and the win and game-over conditions.
- Sits between the button inputs, the frame timer and the ball and block datapaths. Its counters feed the HUD/display logic.

Parameters:
- LIVES, 3, balls per game; legal range 1..3.
- N_BLOCKS, 40, destructible blocks per level; legal range 1..63.
- SERVE_DELAY, 60, frame ticks the ball is held at centre before launch; legal range 1..255.
- BLOCK_PTS, 1, score increment per destroyed block.
- SCORE_W, 10, score width in bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_start  in  1  start button, debounced level.
- btn_pause  in  1  pause button, debounced level.
- frame_tick  in  1  one-cycle pulse per video frame.
- endgame_ball  in  1  ball lost, from ball; level, stays high until ball_start is low.
- hit_block  in  1  ball touching a block, from ball/block grid; level, may last several cycles.
- ball_start  out  1  to ball `start`.
- game_over  out  1  to ball `endgame`; high while the ball must be frozen or the game has ended.
- win  out  1  level cleared.
- lives  out  2  remaining balls.
- score  out  SCORE_W  current score.
- blocks_left  out  6  blocks not yet destroyed.
- state  out  3  FSM state, for LEDs.

Behaviour:
- **Reset values:** state=IDLE, lives=LIVES, score=0, blocks_left=N_BLOCKS, serve_cnt=0, ball_start=0, game_over=0, win=0. All edge-detect history flops are 0.
- **Registered outputs:** every output is registered and reflects the new state on the same edge as the state change. There is no combinational path from inputs to outputs.
- **Edge detection:** btn_start, btn_pause, hit_block and endgame_ball are each rising-edge detected (input high now, previous sample low). A held level produces exactly one event.
- **State encoding:** IDLE=0, SERVE=1, PLAY=2, PAUSE=3, LOST=4, OVER=5, WIN=6.
- **IDLE**
  - Outputs: ball_start=0, game_over=0.
  - start_edge → SERVE. On the same edge, load lives=LIVES, score=0, blocks_left=N_BLOCKS, serve_cnt=0.
- **SERVE**
  - Outputs: ball_start=0, which holds the ball at (320,240).
  - serve_cnt increments on each frame_tick.
  - When frame_tick arrives with serve_cnt==SERVE_DELAY-1: go to PLAY and clear serve_cnt.
  - Pause and block events are ignored in this state.
- **PLAY**
  - Outputs: ball_start=1, game_over=0.
  - hit_edge: score += BLOCK_PTS, saturating at 2^SCORE_W-1; blocks_left -= 1.
    - If blocks_left was 1 → WIN.
  - Otherwise, endgame_edge → LOST.
  - Otherwise, pause_edge → PAUSE.
  - Simultaneous hit_edge and endgame_edge: the block is counted first. If that hit clears the level, WIN wins; otherwise go to LOST, with the score still credited.
- **PAUSE**
  - Outputs: ball_start=1, game_over=1, so the ball freezes in place.
  - pause_edge → PLAY.
  - All other events are ignored.
- **LOST** (one cycle)
  - Outputs: ball_start=0.
  - lives -= 1. If lives was 1 → OVER (lives=0); otherwise → SERVE with serve_cnt=0.
- **OVER**
  - Outputs: ball_start=0, game_over=1.
  - start_edge → SERVE with a full reload, as in IDLE.
- **WIN**
  - Outputs: ball_start=0, game_over=1, win=1.
  - start_edge → SERVE with a full reload.
- **Underflow guards:** blocks_left never decrements below 0 and lives never decrements below 0.
- **Reset mid-game:** asserting reset mid-game returns immediately to IDLE with reset values. Any pending edge is discarded.
- **frame_tick in other states:** ignored outside SERVE.

Decomposition:
- **Package game_pkg:**
  - state encodings (IDLE..WIN);
  - width constants LIVES_W=2, BLK_W=6;
  - screen-centre constants X0=320, Y0=240, shared with the ball.
- **Sub-module edge_det:**
  - Ports: clock, reset, d, rise.
  - Behaviour: one flop plus an AND gate.
  - Instantiated four times.

Test Plan:
1. **Serve timing:** reset; pulse btn_start; apply frame_tick every 10 cycles with SERVE_DELAY=3 → state=SERVE with ball_start=0 for exactly 3 ticks; ball_start=1 on the edge after the 3rd tick.
2. **Lose all balls:** in PLAY, raise endgame_ball 3 times, each time holding it until ball_start drops → lives goes 3→2→1→0; the third loss ends in OVER with game_over=1 and ball_start=0; a fourth raise causes no change.
3. **Scoring and win:** with N_BLOCKS=2, hold hit_block high for 5 cycles, then raise it again → score=1 after the first hold (single count), then score=2, blocks_left=0, win=1, state=WIN.
4. **Simultaneous last block and loss:** with blocks_left=1, raise hit_block and endgame_ball in the same cycle → state=WIN, lives unchanged, score incremented.
5. **Pause:** in PLAY, pulse btn_pause → ball_start=1 and game_over=1; hit_block and endgame_ball edges are ignored; pulse btn_pause again → PLAY with counters unchanged.
6. **Async reset:** assert reset asynchronously mid-SERVE, between clock edges → outputs return to reset values immediately, without waiting for a clock edge; state=IDLE and lives=3 after deassertion.
